// File: rtl/step_round_sequencer_pkg.sv
// Shared definitions for the lattice-permutation step/round scheduler and its step controllers.
package step_round_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_FINISH  = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  localparam int DEF_NSTEPS = 5;
  localparam int DEF_ROUNDS = 24;

endpackage

// File: rtl/step_round_sequencer_sync_up_counter.sv
// Up-counter with synchronous clear and count enable; clear wins over enable.
module sync_up_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= {W{1'b0}};
    end else if (clr) begin
      q <= {W{1'b0}};
    end else if (en) begin
      q <= q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/step_round_sequencer.sv
// Sequences NSTEPS step controllers for ROUNDS rounds, owns the shared line-memory
// grant and watches each step with a timeout.
module step_round_sequencer
  import step_round_sequencer_pkg::*;
#(
  parameter int NSTEPS = DEF_NSTEPS,
  parameter int ROUNDS = DEF_ROUNDS,
  parameter int RW     = 5,
  parameter int SW     = 3,
  parameter int TMO    = 1023,
  parameter int TW     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NSTEPS-1:0] stepDone,
  output logic [NSTEPS-1:0] stepStart,
  output logic [NSTEPS-1:0] memGrant,
  output logic [RW-1:0]     round,
  output logic [SW-1:0]     stepIdx,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t        state_r;
  logic [TW-1:0] timer_s;
  logic [SW-1:0] step_nx_s;
  logic          step_clr_s, step_en_s, round_clr_s, round_en_s, timer_clr_s, timer_en_s;
  logic          sel_done_s, last_step_s, last_round_s, tmo_s;

  function automatic logic [NSTEPS-1:0] onehot(input logic [SW-1:0] idx);
    logic [NSTEPS-1:0] one;
    one = {{(NSTEPS-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

  assign sel_done_s   = stepDone[stepIdx];
  assign last_step_s  = (stepIdx == SW'(NSTEPS - 1));
  assign last_round_s = (round == RW'(ROUNDS - 1));
  assign tmo_s        = (timer_s == TW'(TMO));

  // Counter controls follow the transition the FSM takes this cycle.
  always_comb begin
    step_clr_s  = 1'b0;
    step_en_s   = 1'b0;
    round_clr_s = 1'b0;
    round_en_s  = 1'b0;
    timer_clr_s = 1'b0;
    timer_en_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_ERROR: begin
        step_clr_s  = start;
        round_clr_s = start;
      end
      ST_LAUNCH: timer_clr_s = 1'b1;
      ST_WAIT:   timer_en_s  = !sel_done_s && !tmo_s;
      ST_ADVANCE: begin
        if (!last_step_s) begin
          step_en_s = 1'b1;
        end else if (!last_round_s) begin
          step_clr_s = 1'b1;
          round_en_s = 1'b1;
        end else begin
          step_en_s = 1'b0;
        end
      end
      default: begin
        step_en_s = 1'b0;
      end
    endcase
  end

  // Step index as it will be after this edge, so grants line up with the new step.
  always_comb begin
    if (step_clr_s) begin
      step_nx_s = {SW{1'b0}};
    end else if (step_en_s) begin
      step_nx_s = stepIdx + {{(SW-1){1'b0}}, 1'b1};
    end else begin
      step_nx_s = stepIdx;
    end
  end

  // Scheduler FSM with registered handshake, grant and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      stepStart <= {NSTEPS{1'b0}};
      memGrant  <= {NSTEPS{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      stepStart <= {NSTEPS{1'b0}};
      done      <= 1'b0;
      case (state_r)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            state_r   <= ST_LAUNCH;
            stepStart <= onehot(step_nx_s);
            memGrant  <= onehot(step_nx_s);
            busy      <= 1'b1;
            error     <= 1'b0;
          end else begin
            memGrant <= {NSTEPS{1'b0}};
            busy     <= 1'b0;
          end
        end
        ST_LAUNCH: state_r <= ST_WAIT;
        ST_WAIT: begin
          // Done has priority over a timeout landing on the same cycle.
          if (sel_done_s) begin
            state_r  <= ST_ADVANCE;
            memGrant <= {NSTEPS{1'b0}};
          end else if (tmo_s) begin
            state_r  <= ST_ERROR;
            memGrant <= {NSTEPS{1'b0}};
            busy     <= 1'b0;
            error    <= 1'b1;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_ADVANCE: begin
          if (last_step_s && last_round_s) begin
            state_r <= ST_FINISH;
            done    <= 1'b1;
          end else begin
            state_r   <= ST_LAUNCH;
            stepStart <= onehot(step_nx_s);
            memGrant  <= onehot(step_nx_s);
          end
        end
        ST_FINISH: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r  <= ST_IDLE;
          memGrant <= {NSTEPS{1'b0}};
          busy     <= 1'b0;
          error    <= 1'b0;
        end
      endcase
    end
  end

  sync_up_counter #(.W(SW)) u_step (
    .clk(clk), .rst(rst), .clr(step_clr_s), .en(step_en_s), .q(stepIdx)
  );

  sync_up_counter #(.W(RW)) u_round (
    .clk(clk), .rst(rst), .clr(round_clr_s), .en(round_en_s), .q(round)
  );

  sync_up_counter #(.W(TW)) u_timer (
    .clk(clk), .rst(rst), .clr(timer_clr_s), .en(timer_en_s), .q(timer_s)
  );

endmodule
